// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment order is {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h27, 8'h7F, 8'h6F
  };

  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // ceil(w * 0.302) + 1 decimal digits hold any w-bit value
  function automatic int bcd_digits(int w);
    return (w * 302 + 999) / 1000 + 1;
  endfunction

  function automatic logic [7:0] seg_of(bcd_t d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
// done pulses VALUE_W+1 cycles after an accepted start.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [VALUE_W-1:0]              value,
  output logic                            done,
  output logic [4*bcd_digits(VALUE_W)-1:0] bcd
);

  localparam int NB  = bcd_digits(VALUE_W);
  localparam int CNW = $clog2(VALUE_W + 1);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNW-1:0]     cnt_q, cnt_d;
  logic [VALUE_W-1:0] sh_q, sh_d;
  logic [4*NB-1:0]    acc_q, acc_d;
  logic [4*NB-1:0]    adj;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    acc_d  = acc_q;
    adj    = acc_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CNW'(VALUE_W);
        sh_d   = value;
        acc_d  = '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (adj[i*4 +: 4] >= 4'd5) begin
          adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
      end
      acc_d = {adj[4*NB-2:0], sh_q[VALUE_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      acc_q  <= acc_d;
    end
  end

  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment driver: cell rotation, BCD conversion,
// digit scan with a blank slot, leading-zero blanking, overflow dash.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int N_CELLS      = 8,
  parameter int VALUE_W      = 8,
  parameter int N_DIGITS     = 3,
  parameter int SCAN_DIV     = 2**18,
  parameter int DWELL_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CELLS*VALUE_W-1:0]   cells,
  input  logic                         manual,
  input  logic [$clog2(N_CELLS)-1:0]   sel_cell,
  input  logic                         blank_lz,
  output logic [N_DIGITS-1:0]          digit,
  output logic [7:0]                   out,
  output logic [$clog2(N_CELLS)-1:0]   cell_idx,
  output logic                         frame_start
);

  localparam int CW  = $clog2(N_CELLS);
  localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW  = $clog2(N_DIGITS + 1);
  localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int NB  = bcd_digits(VALUE_W);

  logic               first_q, first_d;
  logic [DVW-1:0]     div_q, div_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [DWW-1:0]     dwell_q, dwell_d;
  logic [CW-1:0]      cell_idx_q, cell_idx_d;
  logic               fs_q, fs_d;
  logic [N_DIGITS-1:0] digit_q, digit_d;
  logic [7:0]         out_q, out_d;
  bcd_t               disp_q [N_DIGITS];
  bcd_t               disp_d [N_DIGITS];
  logic               ovf_q, ovf_d;

  logic               div_wrap;
  logic               last_slot;
  logic               bnd;
  logic [VALUE_W-1:0] conv_val;
  logic               conv_done;
  logic [4*NB-1:0]    conv_bcd;
  logic [4*(NB+N_DIGITS)-1:0] bcd_ext;
  int                 k;
  logic               lead;
  bcd_t               cur;

  assign bcd_ext = {{(4*N_DIGITS){1'b0}}, conv_bcd};

  // The first cycle after reset is treated as a frame boundary.
  always_comb begin
    first_d    = 1'b0;
    div_wrap   = (div_q == DVW'(SCAN_DIV - 1));
    last_slot  = (slot_q == SW'(N_DIGITS));
    bnd        = first_q || (div_wrap && last_slot);
    fs_d       = bnd;
    div_d      = (first_q || div_wrap) ? '0 : div_q + 1'b1;
    slot_d     = slot_q;
    if (!first_q && div_wrap) begin
      slot_d = last_slot ? '0 : slot_q + 1'b1;
    end
    dwell_d    = dwell_q;
    cell_idx_d = cell_idx_q;
    if (bnd) begin
      if (manual) begin
        dwell_d = '0;
        if (32'(sel_cell) < N_CELLS) begin
          cell_idx_d = sel_cell;
        end
      end else if (dwell_q == DWW'(DWELL_FRAMES - 1)) begin
        dwell_d    = '0;
        cell_idx_d = (cell_idx_q == CW'(N_CELLS - 1)) ? '0 : cell_idx_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    conv_val = '0;
    for (int c = 0; c < N_CELLS; c++) begin
      if (cell_idx_d == CW'(c)) begin
        conv_val = cells[c*VALUE_W +: VALUE_W];
      end
    end
  end

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst),
    .start (bnd),
    .value (conv_val),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done) begin
      ovf_d = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        disp_d[i] = bcd_ext[i*4 +: 4];
      end
      for (int i = N_DIGITS; i < NB; i++) begin
        if (bcd_ext[i*4 +: 4] != 4'd0) ovf_d = 1'b1;
      end
    end
  end

  // Slot 0 is an all-off slot; slot s drives digit N_DIGITS-s.
  always_comb begin
    k       = N_DIGITS - int'(slot_q);
    digit_d = '0;
    out_d   = SEG_BLANK;
    lead    = 1'b1;
    cur     = '0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j == k) cur = disp_q[j];
      if (j >= k && disp_q[j] != 4'd0) lead = 1'b0;
    end
    if (slot_q != '0) begin
      for (int j = 0; j < N_DIGITS; j++) begin
        digit_d[j] = (j == k);
      end
      unique case (1'b1)
        ovf_q:
          out_d = SEG_DASH;
        !ovf_q && blank_lz && lead && (k != 0):
          out_d = SEG_BLANK;
        default:
          out_d = seg_of(cur);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q    <= 1'b1;
      div_q      <= '0;
      slot_q     <= '0;
      dwell_q    <= '0;
      cell_idx_q <= '0;
      fs_q       <= 1'b0;
      digit_q    <= '0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) disp_q[i] <= '0;
    end else begin
      first_q    <= first_d;
      div_q      <= div_d;
      slot_q     <= slot_d;
      dwell_q    <= dwell_d;
      cell_idx_q <= cell_idx_d;
      fs_q       <= fs_d;
      digit_q    <= digit_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
    end
  end

  assign digit       = digit_q;
  assign out         = out_q;
  assign cell_idx    = cell_idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed + random bench for seg7_scan_display, two instances
// (8-bit x4 cells, 10-bit x5 cells) on a shared clock and reset.
module tb_seg7_scan_display;

  localparam int SD    = 16;
  localparam int ND    = 3;
  localparam int DWELL = 2;
  localparam logic [7:0] TAB [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h27, 8'h7F, 8'h6F
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cells_a;
  logic        man_a;
  logic [1:0]  sel_a;
  logic [2:0]  digit_a;
  logic [7:0]  out_a;
  logic [1:0]  idx_a;
  logic        fs_a;
  logic [49:0] cells_b;
  logic        man_b;
  logic [2:0]  sel_b;
  logic [2:0]  digit_b;
  logic [7:0]  out_b;
  logic [2:0]  idx_b;
  logic        fs_b;
  logic        lz;

  int total = 0;
  int bad   = 0;
  int ia, dwa, ib, va, vb;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .N_CELLS(4), .VALUE_W(8), .N_DIGITS(ND),
    .SCAN_DIV(SD), .DWELL_FRAMES(DWELL)
  ) u_a (
    .clk(clk), .rst(rst), .cells(cells_a), .manual(man_a),
    .sel_cell(sel_a), .blank_lz(lz), .digit(digit_a), .out(out_a),
    .cell_idx(idx_a), .frame_start(fs_a)
  );

  seg7_scan_display #(
    .N_CELLS(5), .VALUE_W(10), .N_DIGITS(ND),
    .SCAN_DIV(SD), .DWELL_FRAMES(DWELL)
  ) u_b (
    .clk(clk), .rst(rst), .cells(cells_b), .manual(man_b),
    .sel_cell(sel_b), .blank_lz(lz), .digit(digit_b), .out(out_b),
    .cell_idx(idx_b), .frame_start(fs_b)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_exp(int v, int kd, bit blank);
    int p = 1;
    for (int i = 0; i < kd; i++) p *= 10;
    if (v >= 1000) return 8'h40;
    if (blank && kd > 0 && v < p) return 8'h00;
    return TAB[(v / p) % 10];
  endfunction

  task automatic model_step();
    if (man_a) begin
      dwa = 0;
      ia  = int'(sel_a);
    end else if (dwa == DWELL - 1) begin
      dwa = 0;
      ia  = (ia + 1) % 4;
    end else begin
      dwa++;
    end
    if (sel_b < 3'd5) ib = int'(sel_b);
    va = int'(cells_a[ia*8 +: 8]);
    vb = int'(cells_b[ib*10 +: 10]);
  endtask

  task automatic sync_fs();
    int n = 0;
    @(negedge clk);
    while (fs_a !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fs_wait", 32'(n < 200), 1);
    chk("fs_b", 32'(fs_b), 1);
    model_step();
  endtask

  task automatic check_frame();
    int off = 1;
    logic [31:0] ed;
    @(negedge clk);
    chk("fs_pulse", 32'(fs_a), 0);
    for (int s = 0; s <= ND; s++) begin
      while (off < s*SD + 8) begin
        @(negedge clk);
        off++;
      end
      ed = (s == 0) ? 0 : (32'd1 << (ND - s));
      chk($sformatf("a_dig_s%0d", s), 32'(digit_a), ed);
      chk($sformatf("b_dig_s%0d", s), 32'(digit_b), ed);
      chk($sformatf("a_out_s%0d_v%0d", s, va), 32'(out_a),
          (s == 0) ? 0 : 32'(seg_exp(va, ND - s, lz)));
      chk($sformatf("b_out_s%0d_v%0d", s, vb), 32'(out_b),
          (s == 0) ? 0 : 32'(seg_exp(vb, ND - s, lz)));
      chk($sformatf("a_idx_s%0d", s), 32'(idx_a), 32'(ia));
      chk($sformatf("b_idx_s%0d", s), 32'(idx_b), 32'(ib));
    end
  endtask

  initial begin
    rst     = 1'b0;
    man_a   = 1'b0;
    sel_a   = '0;
    man_b   = 1'b1;
    sel_b   = '0;
    lz      = 1'b0;
    cells_a = {4{8'd123}};
    cells_b = '0;
    cells_b[0 +: 10] = 10'd1000;
    ia = 0; dwa = 0; ib = 0; va = 0; vb = 0;

    repeat (3) @(negedge clk);
    chk("rst_digit", 32'(digit_a), 0);
    chk("rst_out", 32'(out_a), 0);
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_fs", 32'(fs_a), 0);
    chk("rst_b_out", 32'(out_b), 0);
    rst = 1'b1;

    // 123 on every cell, overflow 1000 on the wide instance
    sync_fs();
    check_frame();

    // auto rotation over random cell values
    for (int c = 0; c < 4; c++) cells_a[c*8 +: 8] = 8'($urandom_range(0, 255));
    cells_b[0 +: 10] = 10'd999;
    for (int f = 0; f < 8; f++) begin
      lz = 1'($urandom_range(0, 1));
      sync_fs();
      check_frame();
    end

    // small values with and without leading-zero blanking
    man_a = 1'b1;
    sel_a = 2'd1;
    cells_a[8 +: 8] = 8'd7;
    sel_b = 3'd1;
    cells_b[10 +: 10] = 10'($urandom_range(0, 1023));
    lz = 1'b0;
    sync_fs();
    check_frame();
    lz = 1'b1;
    sync_fs();
    check_frame();
    cells_a[8 +: 8] = 8'd0;
    sync_fs();
    check_frame();

    // mid-frame selection and data changes wait for the next boundary
    sync_fs();
    sel_a = 2'd2;
    cells_a[16 +: 8] = 8'($urandom_range(0, 255));
    sel_b = 3'd5;
    check_frame();
    sync_fs();
    check_frame();
    sync_fs();
    cells_a[16 +: 8] = 8'($urandom_range(0, 255));
    sel_b = 3'd7;
    check_frame();
    sync_fs();
    check_frame();
    sel_b = 3'd4;
    cells_b[40 +: 10] = 10'($urandom_range(0, 1023));
    lz = 1'($urandom_range(0, 1));
    sync_fs();
    check_frame();

    // back to auto: rotation resumes from the current cell
    man_a = 1'b0;
    for (int f = 0; f < 3; f++) begin
      sync_fs();
      check_frame();
    end

    // asynchronous reset in the middle of slot 2
    sync_fs();
    repeat (40) @(negedge clk);
    chk("pre_rst_digit", 32'(digit_a), 32'b010);
    rst = 1'b0;
    #1;
    chk("arst_digit", 32'(digit_a), 0);
    chk("arst_out", 32'(out_a), 0);
    chk("arst_idx", 32'(idx_a), 0);
    chk("arst_b_digit", 32'(digit_b), 0);
    chk("arst_b_idx", 32'(idx_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
